// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: shares one Avalon-MM master port among three requesters
// (r0 vertex fetch, r1 depth fetch, r2 z-test write-back). One transfer per grant,
// round-robin by default. Reads are tracked in an in-order ID FIFO so each
// readdatavalid is steered back to the requester that issued it.
// Optional build macro ARB_FIXED_PRIORITY_EN: fixed priority r2 > r1 > r0.
module avalon_master_arbiter #(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [3:0]        r0_byteenable,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  output logic              r0_waitrequest,

  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [3:0]        r1_byteenable,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic              r1_waitrequest,

  input  logic [ADDR_W-1:0] r2_address,
  input  logic              r2_read,
  input  logic              r2_write,
  input  logic [3:0]        r2_byteenable,
  input  logic [DATA_W-1:0] r2_writedata,
  output logic [DATA_W-1:0] r2_readdata,
  output logic              r2_readdatavalid,
  output logic              r2_waitrequest,

  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest,

  output logic              resp_error
);

  localparam int PTR_W = $clog2(MAX_PENDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  state_t            state_nxt;

  // Requester inputs gathered into indexable form
  logic [ADDR_W-1:0] req_address   [3];
  logic [3:0]        req_byteenable[3];
  logic [DATA_W-1:0] req_writedata [3];
  logic [2:0]        req_read;
  logic [2:0]        req_write;

  // Arbitration
  logic [2:0]        eligible;
  logic [1:0]        pick;
  logic              pick_valid;
  logic [1:0]        grant;
  logic [1:0]        last_grant;
  logic              grant_rd;
  logic              sel_read;
  logic              sel_write;
  logic [2:0]        wait_v;
`ifndef ARB_FIXED_PRIORITY_EN
  logic [1:0]        cand;
`endif

  // ID FIFO
  logic [1:0]        id_mem [MAX_PENDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [1:0]        head;

  assign req_address[0]    = r0_address;
  assign req_address[1]    = r1_address;
  assign req_address[2]    = r2_address;
  assign req_byteenable[0] = r0_byteenable;
  assign req_byteenable[1] = r1_byteenable;
  assign req_byteenable[2] = r2_byteenable;
  assign req_writedata[0]  = r0_writedata;
  assign req_writedata[1]  = r1_writedata;
  assign req_writedata[2]  = r2_writedata;
  assign req_read          = {r2_read, r1_read, r0_read};
  assign req_write         = {r2_write, r1_write, r0_write};

  // A read is only eligible when the ID FIFO has room (registered count).
  assign eligible = (req_read & {3{~fifo_full}}) | req_write;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Choose the next requester to grant from the current eligibility
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int unsigned i = 0; i < 3; i++) begin
      if (eligible[i]) begin
        pick       = 2'(i);
        pick_valid = 1'b1;
      end
    end
`else
    cand = next_id(last_grant);
    for (int unsigned i = 0; i < 3; i++) begin
      if (!pick_valid && eligible[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
      cand = next_id(cand);
    end
`endif
  end

  // The transfer type is fixed at grant time (read wins over a simultaneous
  // write); a read that was blocked by a full FIFO never reaches the bus, so
  // the command cannot flip mid-stall when the FIFO drains.
  assign sel_read  = (state == GRANT) && req_read[grant]  && grant_rd;
  assign sel_write = (state == GRANT) && req_write[grant] && !grant_rd;

  // State register with grant bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 2'd2;
      grant_rd   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        grant      <= pick;
        last_grant <= pick;
        grant_rd   <= req_read[pick] && !fifo_full;
      end
    end
  end

  // Next-state: grant on any eligible request, release on completion or drop
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = GRANT;
      GRANT:   if (!(sel_read || sel_write) || !m_waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: mux the granted requester onto the master port
  always_comb begin
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    m_read       = sel_read;
    m_write      = sel_write;
    wait_v       = '1;
    if (state == GRANT) begin
      m_address     = req_address[grant];
      m_byteenable  = req_byteenable[grant];
      m_writedata   = req_writedata[grant];
      wait_v[grant] = m_waitrequest;
    end
  end

  assign r0_waitrequest = wait_v[0];
  assign r1_waitrequest = wait_v[1];
  assign r2_waitrequest = wait_v[2];

  assign fifo_full  = (count == CNT_W'(MAX_PENDING));
  assign fifo_empty = (count == '0);
  assign push       = sel_read && !m_waitrequest;
  assign pop        = m_readdatavalid && !fifo_empty;
  assign head       = id_mem[rd_ptr];

  // ID FIFO pointers, occupancy and sticky orphan-response flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_error <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (m_readdatavalid && fifo_empty) resp_error <= 1'b1;
    end
  end

  // ID FIFO storage: record which requester issued each accepted read
  always_ff @(posedge clock) begin
    if (push) id_mem[wr_ptr] <= grant;
  end

  assign r0_readdata      = m_readdata;
  assign r1_readdata      = m_readdata;
  assign r2_readdata      = m_readdata;
  assign r0_readdatavalid = pop && (head == 2'd0);
  assign r1_readdatavalid = pop && (head == 2'd1);
  assign r2_readdatavalid = pop && (head == 2'd2);

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// tb_avalon_master_arbiter: directed tests for avalon_master_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_avalon_master_arbiter;

  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] r0_address, r1_address, r2_address;
  logic              r0_read, r1_read, r2_read;
  logic              r0_write, r1_write, r2_write;
  logic [3:0]        r0_byteenable, r1_byteenable, r2_byteenable;
  logic [DATA_W-1:0] r0_writedata, r1_writedata, r2_writedata;
  logic [DATA_W-1:0] r0_readdata, r1_readdata, r2_readdata;
  logic              r0_readdatavalid, r1_readdatavalid, r2_readdatavalid;
  logic              r0_waitrequest, r1_waitrequest, r2_waitrequest;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_readdatavalid;
  logic              m_waitrequest;
  logic              resp_error;

  logic [2:0] rdv;
  logic [2:0] wait_v;
  assign rdv    = {r2_readdatavalid, r1_readdatavalid, r0_readdatavalid};
  assign wait_v = {r2_waitrequest, r1_waitrequest, r0_waitrequest};

  int total = 0;
  int bad   = 0;

  avalon_master_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clock(clock), .reset(reset),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_byteenable(r0_byteenable), .r0_writedata(r0_writedata),
    .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
    .r0_waitrequest(r0_waitrequest),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_byteenable(r1_byteenable), .r1_writedata(r1_writedata),
    .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
    .r1_waitrequest(r1_waitrequest),
    .r2_address(r2_address), .r2_read(r2_read), .r2_write(r2_write),
    .r2_byteenable(r2_byteenable), .r2_writedata(r2_writedata),
    .r2_readdata(r2_readdata), .r2_readdatavalid(r2_readdatavalid),
    .r2_waitrequest(r2_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .resp_error(resp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_req(input int id, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    case (id)
      0: begin r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = 4'hF; end
      1: begin r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = 4'hF; end
      default: begin r2_read = rd; r2_write = wr; r2_address = a; r2_writedata = d; r2_byteenable = 4'hF; end
    endcase
  endtask

  // Drives one request, waits (bounded) for waitrequest low, holds through
  // the accepting edge, then releases. waited = negedges spent waiting, -1 on timeout.
  task automatic issue_xfer(input int id, input logic is_read, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, output int waited);
    @(negedge clock);
    set_req(id, is_read, !is_read, a, d);
    waited = -1;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (wait_v[id] === 1'b0) begin
        waited = n;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    set_req(id, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    total++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      bad++; $display("FAIL reset_cmd: m_read=%b m_write=%b expected 0 0", m_read, m_write);
    end
    total++;
    if (m_address !== '0 || m_byteenable !== 4'h0 || m_writedata !== '0) begin
      bad++; $display("FAIL reset_bus: addr=%h be=%h wd=%h expected zeros", m_address, m_byteenable, m_writedata);
    end
    total++;
    if (wait_v !== 3'b111) begin
      bad++; $display("FAIL reset_wait: got %b expected 111", wait_v);
    end
    total++;
    if (rdv !== 3'b000 || resp_error !== 1'b0) begin
      bad++; $display("FAIL reset_resp: rdv=%b resp_error=%b expected 000 0", rdv, resp_error);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clock);
    r0_address = 26'h100; r0_byteenable = 4'hF; r0_read = 1'b1; m_waitrequest = 1'b0;
    #1;
    total++;
    if (wait_v !== 3'b111 || m_read !== 1'b0) begin
      bad++; $display("FAIL single_idle: wait=%b m_read=%b expected 111 0", wait_v, m_read);
    end
    @(negedge clock);
    #1;
    total++;
    if (m_read !== 1'b1 || m_address !== 26'h100 || m_byteenable !== 4'hF) begin
      bad++; $display("FAIL single_grant: m_read=%b addr=%h be=%h expected 1 100 f", m_read, m_address, m_byteenable);
    end
    total++;
    if (wait_v !== 3'b110) begin
      bad++; $display("FAIL single_grant_wait: got %b expected 110", wait_v);
    end
    @(negedge clock);
    r0_read = 1'b0;
    #1;
    total++;
    if (m_read !== 1'b0 || wait_v !== 3'b111) begin
      bad++; $display("FAIL single_bubble: m_read=%b wait=%b expected 0 111", m_read, wait_v);
    end
    @(negedge clock);
    @(negedge clock);
    m_readdatavalid = 1'b1; m_readdata = 32'hDEADBEEF;
    #1;
    total++;
    if (rdv !== 3'b001) begin
      bad++; $display("FAIL single_rdv: got %b expected 001", rdv);
    end
    total++;
    if (r0_readdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_data: got %h expected deadbeef", r0_readdata);
    end
    @(negedge clock);
    m_readdatavalid = 1'b0;
    #1;
    total++;
    if (rdv !== 3'b000 || resp_error !== 1'b0) begin
      bad++; $display("FAIL single_after: rdv=%b resp_error=%b expected 000 0", rdv, resp_error);
    end
  endtask

  task automatic test_contention();
    int g;
    logic [2:0] exp_w;
    do_reset();
    @(negedge clock);
    m_waitrequest = 1'b0;
    set_req(0, 1'b0, 1'b1, 26'h0A0, 32'h1000_0000);
    set_req(1, 1'b0, 1'b1, 26'h0A1, 32'h1000_0001);
    set_req(2, 1'b0, 1'b1, 26'h0A2, 32'h1000_0002);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      #1;
      if (k % 2 == 0) begin
`ifdef ARB_FIXED_PRIORITY_EN
        g = 2;
`else
        g = (k / 2) % 3;
`endif
        exp_w = 3'b111 & ~(3'b001 << g);
        total++;
        if (m_write !== 1'b1 || m_address !== 26'h0A0 + 26'(g) || m_writedata !== 32'h1000_0000 + 32'(g)) begin
          bad++; $display("FAIL contention_grant k=%0d: write=%b addr=%h wd=%h expected requester %0d",
                          k, m_write, m_address, m_writedata, g);
        end
        total++;
        if (wait_v !== exp_w) begin
          bad++; $display("FAIL contention_wait k=%0d: got %b expected %b", k, wait_v, exp_w);
        end
      end else begin
        total++;
        if (m_write !== 1'b0 || wait_v !== 3'b111) begin
          bad++; $display("FAIL contention_bubble k=%0d: write=%b wait=%b expected 0 111", k, m_write, wait_v);
        end
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_ordering();
    int w1, w0, w2;
    logic [2:0]  exp_rdv [3];
    logic [31:0] rdata   [3];
    exp_rdv[0] = 3'b010; exp_rdv[1] = 3'b001; exp_rdv[2] = 3'b100;
    rdata[0] = 32'h0000_00A1; rdata[1] = 32'h0000_00A0; rdata[2] = 32'h0000_00A2;
    issue_xfer(1, 1'b1, 26'h10, '0, w1);
    issue_xfer(0, 1'b1, 26'h20, '0, w0);
    issue_xfer(2, 1'b1, 26'h30, '0, w2);
    total++;
    if (w1 !== 1 || w0 !== 1 || w2 !== 1) begin
      bad++; $display("FAIL order_latency: waits=%0d,%0d,%0d expected 1,1,1", w1, w0, w2);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      m_readdatavalid = 1'b1; m_readdata = rdata[i];
      #1;
      total++;
      if (rdv !== exp_rdv[i] || m_readdata !== r0_readdata || r1_readdata !== rdata[i]) begin
        bad++; $display("FAIL order_resp%0d: rdv=%b data=%h expected %b %h", i, rdv, r1_readdata, exp_rdv[i], rdata[i]);
      end
    end
    @(negedge clock);
    m_readdatavalid = 1'b0;
    #1;
    total++;
    if (resp_error !== 1'b0) begin
      bad++; $display("FAIL order_err: resp_error=%b expected 0", resp_error);
    end
  endtask

  task automatic test_fifo_full();
    int w;
    int slow;
    do_reset();
    slow = 0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      issue_xfer(0, 1'b1, 26'h200 + 26'(i), '0, w);
      if (w !== 1) slow++;
    end
    total++;
    if (slow !== 0) begin
      bad++; $display("FAIL full_fill: %0d reads not accepted in 1 cycle, expected 0", slow);
    end
    @(negedge clock);
    r1_address = 26'h300; r1_byteenable = 4'hF; r1_read = 1'b1;
    set_req(2, 1'b0, 1'b1, 26'h3F0, 32'h0000_55AA);
    @(negedge clock);
    #1;
    total++;
    if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 26'h3F0 || wait_v !== 3'b011) begin
      bad++; $display("FAIL full_write_grant: w=%b r=%b addr=%h wait=%b expected 1 0 3f0 011",
                      m_write, m_read, m_address, wait_v);
    end
    @(negedge clock);
    set_req(2, 1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (m_read !== 1'b0 || r1_waitrequest !== 1'b1) begin
      bad++; $display("FAIL full_hold1: m_read=%b r1_wait=%b expected 0 1", m_read, r1_waitrequest);
    end
    @(negedge clock);
    #1;
    total++;
    if (m_read !== 1'b0 || r1_waitrequest !== 1'b1) begin
      bad++; $display("FAIL full_hold2: m_read=%b r1_wait=%b expected 0 1", m_read, r1_waitrequest);
    end
    m_readdatavalid = 1'b1; m_readdata = 32'h0000_0000;
    #1;
    total++;
    if (rdv !== 3'b001) begin
      bad++; $display("FAIL full_pop_rdv: got %b expected 001", rdv);
    end
    @(negedge clock);
    m_readdatavalid = 1'b0;
    #1;
    total++;
    if (m_read !== 1'b0 || r1_waitrequest !== 1'b1) begin
      bad++; $display("FAIL full_same_cycle_pop: m_read=%b r1_wait=%b expected 0 1", m_read, r1_waitrequest);
    end
    @(negedge clock);
    #1;
    total++;
    if (m_read !== 1'b1 || m_address !== 26'h300 || wait_v !== 3'b101) begin
      bad++; $display("FAIL full_ninth: m_read=%b addr=%h wait=%b expected 1 300 101", m_read, m_address, wait_v);
    end
    @(negedge clock);
    r1_read = 1'b0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      @(negedge clock);
      m_readdatavalid = 1'b1; m_readdata = 32'(i);
      #1;
      total++;
      if (rdv !== ((i < MAX_PENDING - 1) ? 3'b001 : 3'b010)) begin
        bad++; $display("FAIL full_drain%0d: rdv=%b expected %b", i, rdv,
                        (i < MAX_PENDING - 1) ? 3'b001 : 3'b010);
      end
    end
    @(negedge clock);
    m_readdatavalid = 1'b0;
  endtask

  task automatic test_stall_hold();
    @(negedge clock);
    m_waitrequest = 1'b1;
    r1_address = 26'h3C; r1_writedata = 32'hCAFEF00D; r1_byteenable = 4'h3; r1_write = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 0) set_req(0, 1'b0, 1'b1, 26'h77, 32'h1234_5678);
      #1;
      total++;
      if (m_write !== 1'b1 || m_address !== 26'h3C || m_writedata !== 32'hCAFEF00D || m_byteenable !== 4'h3) begin
        bad++; $display("FAIL stall_bus c=%0d: w=%b addr=%h wd=%h be=%h expected 1 3c cafef00d 3",
                        c, m_write, m_address, m_writedata, m_byteenable);
      end
      total++;
      if (wait_v !== 3'b111) begin
        bad++; $display("FAIL stall_wait c=%0d: got %b expected 111", c, wait_v);
      end
    end
    @(negedge clock);
    m_waitrequest = 1'b0;
    #1;
    total++;
    if (wait_v !== 3'b101 || m_address !== 26'h3C) begin
      bad++; $display("FAIL stall_release: wait=%b addr=%h expected 101 3c", wait_v, m_address);
    end
    @(negedge clock);
    r1_write = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    total++;
    if (wait_v !== 3'b111 || m_write !== 1'b0) begin
      bad++; $display("FAIL stall_done: wait=%b w=%b expected 111 0", wait_v, m_write);
    end
  endtask

  task automatic test_empty_response();
    @(negedge clock);
    m_readdatavalid = 1'b1; m_readdata = 32'h1234_5678;
    #1;
    total++;
    if (rdv !== 3'b000) begin
      bad++; $display("FAIL empty_rdv: got %b expected 000", rdv);
    end
    @(negedge clock);
    m_readdatavalid = 1'b0;
    #1;
    total++;
    if (resp_error !== 1'b1) begin
      bad++; $display("FAIL empty_err: resp_error=%b expected 1", resp_error);
    end
    repeat (3) @(negedge clock);
    #1;
    total++;
    if (resp_error !== 1'b1) begin
      bad++; $display("FAIL empty_sticky: resp_error=%b expected 1", resp_error);
    end
    do_reset();
    #1;
    total++;
    if (resp_error !== 1'b0) begin
      bad++; $display("FAIL empty_reset: resp_error=%b expected 0", resp_error);
    end
  endtask

  initial begin
    r0_address = '0; r1_address = '0; r2_address = '0;
    r0_read = 1'b0; r1_read = 1'b0; r2_read = 1'b0;
    r0_write = 1'b0; r1_write = 1'b0; r2_write = 1'b0;
    r0_byteenable = '0; r1_byteenable = '0; r2_byteenable = '0;
    r0_writedata = '0; r1_writedata = '0; r2_writedata = '0;
    m_readdata = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;

    test_reset();
    test_single_read();
    test_contention();
    test_ordering();
    test_fifo_full();
    test_stall_hold();
    test_empty_response();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon_master_arbiter.md
Name: avalon_master_arbiter

Overview:
- Shares one downstream Avalon-MM master port (SDRAM controller) among three Avalon-MM requesters: vertex fetch (r0), depth fetch (r1) and z-test write-back (r2).
- Arbitration is round-robin, one transfer per grant.
- Pipelined reads are supported: an in-order ID FIFO routes each readdatavalid back to the requester that issued the read.
- Sits between the rasterizer pipeline masters and the single SDRAM slave.

Parameters:
ADDR_W, 26, address width of every port
DATA_W, 32, data width of every port
MAX_PENDING, 8, outstanding reads tracked; power of 2, ≥2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rN_address  in  ADDR_W  requester N address (N = 0,1,2, one set per requester)
rN_read  in  1  requester N read request
rN_write  in  1  requester N write request
rN_byteenable  in  4  requester N byte enables
rN_writedata  in  DATA_W  requester N write data
rN_readdata  out  DATA_W  copy of m_readdata, broadcast to all requesters
rN_readdatavalid  out  1  read response for requester N
rN_waitrequest  out  1  stall to requester N
m_address  out  ADDR_W  downstream address
m_read  out  1  downstream read
m_write  out  1  downstream write
m_byteenable  out  4  downstream byte enables
m_writedata  out  DATA_W  downstream write data
m_readdata  in  DATA_W  downstream read data
m_readdatavalid  in  1  downstream read response
m_waitrequest  in  1  downstream stall
resp_error  out  1  sticky: a response arrived while the ID FIFO was empty

Behaviour:
- Interface: one clock domain (clock). reset is synchronous and active-high.
- Reset values: state=IDLE, last_grant=2 (so r0 has first priority), FIFO empty, resp_error=0, m_read=m_write=0, m_address=0, m_byteenable=0, m_writedata=0, all rN_readdatavalid=0, all rN_waitrequest=1.
- A requester is eligible when (rN_read && !fifo_full) || rN_write. A read while the FIFO is full is not eligible.
- IDLE:
  - If any requester is eligible, pick the first eligible one scanning from last_grant+1 mod 3.
  - Register it as grant and last_grant; next state is GRANT.
  - If none is eligible, stay in IDLE.
  - All rN_waitrequest=1.
- GRANT:
  - m_* outputs are a combinational mux of the granted requester's inputs.
  - Granted rN_waitrequest = m_waitrequest. Others = 1.
  - Transfer completes when (m_read||m_write) && !m_waitrequest. Then go to IDLE; this gives a 1-cycle bubble and a maximum of 1 transfer per 2 cycles.
  - If the granted requester drops both read and write, go to IDLE next cycle with no transfer.
  - Grant is never revoked while m_waitrequest=1.
- Latency: request first seen at cycle N in IDLE → m_* driven and earliest acceptance at N+1.
- ID FIFO, depth MAX_PENDING, 2-bit entries:
  - Push the grant ID when a read completes.
  - Pop on m_readdatavalid.
  - rN_readdatavalid = m_readdatavalid && head==N, combinational, 0-cycle latency.
  - Push and pop in the same cycle leave the count unchanged.
  - Full/empty come from a count register of width log2(MAX_PENDING)+1. The full check uses the registered count, so a read is not accepted at full even if a pop happens in the same cycle.
  - Pointers wrap modulo MAX_PENDING.
- Writes never enter the FIFO.
- m_readdatavalid with an empty FIFO: drop the response, set resp_error=1 (sticky until reset).
- Reset mid-operation: FIFO cleared and state returns to IDLE. Late responses then set resp_error; the bench treats this as expected after a mid-flight reset.
- Simultaneous read and write from one requester: the read takes precedence for that grant (m_write=0). The write is served on a later grant.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority r2 > r1 > r0 (downstream stages drain first); last_grant is ignored.
- Undefined: round-robin as above.
- FIFO routing and all other behaviour are identical in both builds.

Test Plan:
- Single read: r0_read addr=0x100, m_waitrequest=0, m_readdatavalid 3 cycles later with 0xDEADBEEF → r0_readdatavalid=1 with r0_readdata=0xDEADBEEF; r1/r2 readdatavalid stay 0.
- Contention: r0, r1 and r2 all write continuously → grants r0,r1,r2,r0,… with one transfer every 2 cycles. Under ARB_FIXED_PRIORITY_EN, r2 only.
- Out-of-requester ordering: reads r1@0x10, r0@0x20, r2@0x30 accepted, then 3 responses → readdatavalid pulses on r1, r0, r2 in that order.
- FIFO full: MAX_PENDING=8, issue 8 reads with no response → 9th read held (waitrequest=1) while a write from r2 is still granted. One response → 9th read accepted.
- Stall hold: m_waitrequest=1 for 5 cycles during an r1 write → m_address/m_writedata stable and no regrant; completes on cycle 6.
- Empty response: m_readdatavalid with no outstanding read → resp_error=1, no rN_readdatavalid. After reset, resp_error=0.
